// File: rtl/jk_register_bank.sv
// jk_register_bank
//
// A bank of WIDTH independent flip-flops on one clock. The next-state function
// (JK, D, T or SR) is selected at run time by `mode`. The block also reports
// which bits changed at the last edge, keeps a saturating count of individual
// bit flips, and holds a sticky flag for SR cycles where S=R=1.
//
// There are no handshakes. Every input is sampled on each rising edge of clk
// and takes effect on that edge.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   en         in   1      update enable (0 = hold q, toggle_cnt, sr_err)
//   clr        in   1      synchronous clear, takes priority over en
//   mode       in   2      00 JK, 01 D, 10 T, 11 SR
//   a          in   WIDTH  J / D / T / S per channel
//   b          in   WIDTH  K / - / - / R per channel
//   q          out  WIDTH  registered state
//   q_bar      out  WIDTH  ~q (combinational)
//   changed    out  WIDTH  bits of q that changed at the last edge
//   toggle_cnt out  CNT_W  saturating count of bit flips since rst/clr
//   sr_err     out  1      sticky S=R=1 flag, cleared by rst or clr
module jk_register_bank #(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int unsigned     CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             sr_err
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_func;    // next state from the selected function
  logic [WIDTH-1:0] q_diff;    // bits that flip if the function is applied
  logic [CNT_W:0]   flip_pop;  // popcount of q_diff
  logic [CNT_W:0]   cnt_sum;   // one extra bit so overflow is visible before clamping
  logic [CNT_W-1:0] cnt_next;
  logic             sr_viol;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    q_func = q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (mode_sel)
        MODE_JK: begin
          unique case ({a[i], b[i]})
            2'b00:   q_func[i] = q[i];
            2'b01:   q_func[i] = 1'b0;
            2'b10:   q_func[i] = 1'b1;
            default: q_func[i] = ~q[i];
          endcase
        end
        MODE_D:  q_func[i] = a[i];
        MODE_T:  q_func[i] = a[i] ? ~q[i] : q[i];
        default: begin
          // SR: S=R=1 holds the bit. The violation is flagged separately.
          unique case ({a[i], b[i]})
            2'b10:   q_func[i] = 1'b1;
            2'b01:   q_func[i] = 1'b0;
            default: q_func[i] = q[i];
          endcase
        end
      endcase
    end
  end

  assign q_diff  = q ^ q_func;
  assign sr_viol = (mode_sel == MODE_SR) && (|(a & b));

  always_comb begin
    flip_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip_pop = flip_pop + {{CNT_W{1'b0}}, q_diff[i]};
    end
  end

  assign cnt_sum  = {1'b0, toggle_cnt} + flip_pop;
  assign cnt_next = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= RESET_VALUE;
      changed    <= '0;
      toggle_cnt <= '0;
      sr_err     <= 1'b0;
    end else if (clr) begin
      // Flips caused by clr are reported in `changed` but are not counted.
      q          <= RESET_VALUE;
      changed    <= q ^ RESET_VALUE;
      toggle_cnt <= '0;
      sr_err     <= 1'b0;
    end else if (en) begin
      q          <= q_func;
      changed    <= q_diff;
      toggle_cnt <= cnt_next;
      if (sr_viol) begin
        sr_err <= 1'b1;
      end
    end else begin
      changed <= '0;
    end
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed bench for jk_register_bank. The main instance uses the default
// parameters (WIDTH=8, CNT_W=8). A second instance with CNT_W=4 shares the same
// inputs so that counter saturation can be checked.
module tb_jk_register_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [7:0] a;
  logic [7:0] b;

  logic [7:0] q, q_bar, changed;
  logic [7:0] toggle_cnt;
  logic       sr_err;

  logic [7:0] s_q, s_q_bar, s_changed;
  logic [3:0] s_toggle_cnt;
  logic       s_sr_err;

  int tests;
  int failed;

  jk_register_bank dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .mode       (mode),
    .a          (a),
    .b          (b),
    .q          (q),
    .q_bar      (q_bar),
    .changed    (changed),
    .toggle_cnt (toggle_cnt),
    .sr_err     (sr_err)
  );

  jk_register_bank #(.WIDTH(8), .RESET_VALUE(8'h00), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .mode       (mode),
    .a          (a),
    .b          (b),
    .q          (s_q),
    .q_bar      (s_q_bar),
    .changed    (s_changed),
    .toggle_cnt (s_toggle_cnt),
    .sr_err     (s_sr_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: advance one rising edge and settle 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en_v, input logic clr_v, input logic [1:0] mode_v,
                       input logic [7:0] a_v, input logic [7:0] b_v);
    en   = en_v;
    clr  = clr_v;
    mode = mode_v;
    a    = a_v;
    b    = b_v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_q, input logic [7:0] e_chg,
                         input logic [7:0] e_cnt, input logic e_err);
    chk({tag, ".q"},       {24'h0, q},          {24'h0, e_q});
    chk({tag, ".q_bar"},   {24'h0, q_bar},      {24'h0, ~e_q});
    chk({tag, ".changed"}, {24'h0, changed},    {24'h0, e_chg});
    chk({tag, ".cnt"},     {24'h0, toggle_cnt}, {24'h0, e_cnt});
    chk({tag, ".sr_err"},  {31'h0, sr_err},     {31'h0, e_err});
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 8'h3C, 8'hC3);

    // Reset is asserted before the first clock edge and is checked at once.
    #2 rst = 1'b1;
    #1;
    chk_all("reset_async", 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);

    // JK sweep
    drive(1'b1, 1'b0, 2'b00, 8'hF0, 8'h00); step();
    chk_all("jk_set", 8'hF0, 8'hF0, 8'd4, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 8'hFF, 8'hFF); step();
    chk_all("jk_toggle", 8'h0F, 8'hFF, 8'd12, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h0F); step();
    chk_all("jk_reset", 8'h00, 8'h0F, 8'd16, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00); step();
    chk_all("jk_hold", 8'h00, 8'h00, 8'd16, 1'b0);

    // D, T and enable
    drive(1'b1, 1'b0, 2'b01, 8'hA5, 8'hFF); step();
    chk_all("d_load", 8'hA5, 8'hA5, 8'd20, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 8'hFF, 8'h00); step();
    chk_all("t_all", 8'h5A, 8'hFF, 8'd28, 1'b0);
    drive(1'b0, 1'b0, 2'b10, 8'hFF, 8'h00); step();
    chk_all("en_off", 8'h5A, 8'h00, 8'd28, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 8'h0F, 8'hF0); step();
    chk_all("t_partial", 8'h55, 8'h0F, 8'd32, 1'b0);

    // An SR S=R=1 cycle while en=0 must not set the flag.
    drive(1'b0, 1'b0, 2'b11, 8'hFF, 8'hFF); step();
    chk_all("sr_en_off", 8'h55, 8'h00, 8'd32, 1'b0);

    // Clear, then SR violation
    drive(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00); step();
    chk_all("clr1", 8'h00, 8'h55, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'h03, 8'h01); step();
    chk_all("sr_viol", 8'h02, 8'h02, 8'd1, 1'b1);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00); step();
    chk_all("sr_sticky", 8'h02, 8'h00, 8'd1, 1'b1);
    drive(1'b1, 1'b1, 2'b00, 8'h00, 8'h00); step();
    chk_all("sr_clr", 8'h00, 8'h02, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'hF0, 8'h00); step();
    chk_all("sr_set", 8'hF0, 8'hF0, 8'd4, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'h00, 8'h30); step();
    chk_all("sr_reset", 8'hC0, 8'h30, 8'd6, 1'b0);

    // Saturation on the CNT_W=4 instance
    drive(1'b1, 1'b1, 2'b10, 8'h00, 8'h00); step();
    chk("sat_clr.cnt", {28'h0, s_toggle_cnt}, 32'd0);
    drive(1'b1, 1'b0, 2'b10, 8'hFF, 8'h00); step();
    chk("sat1.q",   {24'h0, s_q},          32'hFF);
    chk("sat1.cnt", {28'h0, s_toggle_cnt}, 32'd8);
    step();
    chk("sat2.q",   {24'h0, s_q},          32'h00);
    chk("sat2.cnt", {28'h0, s_toggle_cnt}, 32'd15);
    chk("nosat2.cnt", {24'h0, toggle_cnt}, 32'd16);
    step();
    chk("sat3.q",   {24'h0, s_q},          32'hFF);
    chk("sat3.cnt", {28'h0, s_toggle_cnt}, 32'd15);
    chk("nosat3.cnt", {24'h0, toggle_cnt}, 32'd24);

    // clr wins over en; no SR error is recorded in that cycle.
    drive(1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF); step();
    chk_all("clr_prio", 8'h00, 8'hFF, 8'd0, 1'b0);

    // Reset between edges takes effect immediately.
    drive(1'b1, 1'b0, 2'b01, 8'h5A, 8'h00); step();
    chk_all("pre_rst", 8'h5A, 8'h5A, 8'd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("rst_mid", 8'h00, 8'h00, 8'd0, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 8'h3C, 8'h00); step();
    chk_all("post_rst", 8'h3C, 8'h3C, 8'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/jk_register_bank.md
# jk_register_bank

Parametrised bank of WIDTH independent flip-flops sharing one clock, with a runtime-selectable next-state function (JK, D, T or SR). It also provides per-bit change flags, a saturating flip counter and a sticky SR-violation flag. It replaces single-bit JK flip-flop instances in board-level lab tops, where switches drive the data/mode inputs and LEDs show the state, counter and flags.

## Interface
Parameters:
- WIDTH, 8, number of flip-flop channels (1..32)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q by rst and clr
- CNT_W, 8, width of toggle_cnt (≥ clog2(WIDTH+1))

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- en  in  1  update enable; 0 = hold all state
- clr  in  1  synchronous clear (priority over en)
- mode  in  2  next-state function: 00 JK, 01 D, 10 T, 11 SR
- a  in  WIDTH  per-channel J / D / T / S input
- b  in  WIDTH  per-channel K / ignored / ignored / R input
- q  out  WIDTH  registered state
- q_bar  out  WIDTH  ~q, combinational
- changed  out  WIDTH  registered; bit i = 1 if q[i] changed at the last edge
- toggle_cnt  out  CNT_W  saturating count of individual bit flips since reset/clr
- sr_err  out  1  sticky; set on an SR-mode cycle with S=R=1 on any bit

## Operation
- Reset values: q = RESET_VALUE, q_bar = ~RESET_VALUE, changed = 0, toggle_cnt = 0, sr_err = 0.
- Priority per edge: rst (async) > clr > en > hold.
- clr=1: q <= RESET_VALUE; changed <= q ^ RESET_VALUE; toggle_cnt <= 0; sr_err <= 0. Flips caused by clr are not counted. mode, a, b and en are ignored.
- en=0, clr=0: q, toggle_cnt and sr_err hold; changed <= 0.
- en=1, clr=0, next-state per bit i:
  - JK: ab = 00 hold, 01 → 0, 10 → 1, 11 → ~q[i].
  - D: q[i] <= a[i]; b is ignored.
  - T: a[i]=1 → ~q[i], else hold; b is ignored.
  - SR: 10 → 1, 01 → 0, 00 hold, 11 → hold that bit and set sr_err.
- changed <= q ^ q_next.
- toggle_cnt <= min(toggle_cnt + popcount(q ^ q_next), 2^CNT_W − 1). Add in CNT_W+1 bits, then clamp.
- sr_err clears only on rst or clr. It is set in the same edge as the violation and stays set across mode changes.
- mode may change on any cycle. The new function applies at the next edge and no state is retained from the previous mode.

## Timing
- Input-to-q latency is 1 clock. changed, toggle_cnt and sr_err update on the same edge as q.
- q_bar follows q combinationally, with no extra cycle.
- rst assertion forces reset values immediately, independent of clk. Deassertion is expected to be synchronous to clk (handled upstream). The first update happens on the first rising edge with rst low.
- rst mid-operation discards any pending update. The counter and sr_err are lost.
- Saturation: at toggle_cnt = 2^CNT_W − 1, the counter holds the value and does not wrap. q continues updating normally.
- Simultaneous clr and en=1: clr wins, and no SR error is recorded that cycle.

## Test plan
- Reset: WIDTH=8, drive rst=1 mid-cycle with arbitrary inputs → q=00, q_bar=FF, changed=00, toggle_cnt=0, sr_err=0 without waiting for a clock edge.
- JK sweep: q=00, mode=00, en=1. Then a=F0,b=00 → q=F0, changed=F0, cnt=4. Then a=FF,b=FF → q=0F, changed=FF, cnt=12. Then a=00,b=0F → q=00, cnt=16. Then a=00,b=00 → hold, changed=00.
- D/T modes: mode=01, a=A5 → q=A5. Then mode=10, a=FF → q=5A, changed=FF. Then en=0 with a=FF → q stays 5A, changed=00, cnt unchanged.
- SR violation: q=00, mode=11, a=03, b=01 → bit1 set, bit0 holds, q=02, sr_err=1. Then mode=00 → sr_err stays 1. Then clr=1 → q=00, cnt=0, sr_err=0, changed=02.
- Saturation: CNT_W=4, mode=10, a=FF for 2 cycles → cnt=15 (8+8 clamped). Further toggles keep cnt=15 while q keeps alternating 00/FF.
- Priority: clr=1, en=1, mode=11, a=b=FF → q=RESET_VALUE, sr_err=0. Then rst pulse between edges with q=5A → q=00 immediately.
